tt_page_loader: RTL

TT_PAGE_LOADER -- requirements
Module: tt_page_loader

---
 rtl/tt_page_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tt_page_loader.sv
// Teletext page loader: copies 1000-byte pages from flash into a back buffer,
// then swaps it to the display front buffer at the next vsync.
module tt_page_loader #(
  parameter int unsigned FLASH_WAIT = 3,
  parameter int unsigned MAX_PAGE   = 485
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        page_req,
  input  logic [8:0]  page_num,
  input  logic        frame_start,
  output logic [20:0] flash_address,
  input  logic [7:0]  flash_data,
  input  logic [9:0]  disp_addr,
  output logic [7:0]  disp_data,
  output logic        busy,
  output logic        page_ready,
  output logic [8:0]  cur_page,
  output logic        req_error
);

  localparam int unsigned PAGE_W    = 9;
  localparam int unsigned OFF_W     = 10;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 21;
  localparam int unsigned LAST_OFF  = 999;
  localparam int unsigned BUF_DEPTH = 2048;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPT,
    S_SWAPWAIT
  } state_t;

  state_t              state_q,      state_d;
  logic                front_q,      front_d;
  logic [PAGE_W-1:0]   cur_page_q,   cur_page_d;
  logic                pend_vld_q,   pend_vld_d;
  logic [PAGE_W-1:0]   pend_page_q,  pend_page_d;
  logic [PAGE_W-1:0]   page_q,       page_d;
  logic [OFF_W-1:0]    off_q,        off_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [ADDR_W-1:0]   flash_addr_q, flash_addr_d;
  logic                busy_q,       busy_d;
  logic                page_ready_q, page_ready_d;
  logic                req_error_q,  req_error_d;
  logic [DATA_W-1:0]   disp_data_q,  disp_data_d;

  // Both page buffers; the top address bit selects the buffer.
  logic [DATA_W-1:0]   mem_q [BUF_DEPTH];

  logic                req_ok_c;
  logic                busy_now_c;
  logic                wr_en_c;
  logic [10:0]         wr_addr_c;

  // Next-state, request handling and registered output values
  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    cur_page_d   = cur_page_q;
    pend_vld_d   = pend_vld_q;
    pend_page_d  = pend_page_q;
    page_d       = page_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    flash_addr_d = flash_addr_q;
    page_ready_d = 1'b0;
    req_error_d  = 1'b0;
    wr_en_c      = 1'b0;
    wr_addr_c    = {~front_q, off_q};

    req_ok_c   = page_req && (32'(page_num) <= MAX_PAGE);
    busy_now_c = (state_q != S_IDLE) || pend_vld_q;

    if (page_req && !req_ok_c) begin
      req_error_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          pend_vld_d   = 1'b0;
          page_d       = pend_page_q;
          off_d        = '0;
          flash_addr_d = {2'b00, pend_page_q, OFF_W'(0)};
          state_d      = S_ADDR;
        end else if (req_ok_c) begin
          page_d       = page_num;
          off_d        = '0;
          flash_addr_d = {2'b00, page_num, OFF_W'(0)};
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = CNT_W'(FLASH_WAIT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPT: begin
        wr_en_c = 1'b1;
        if (off_q == OFF_W'(LAST_OFF)) begin
          state_d = S_SWAPWAIT;
        end else begin
          off_d        = off_q + OFF_W'(1);
          flash_addr_d = {2'b00, page_q, off_q + OFF_W'(1)};
          state_d      = S_ADDR;
        end
      end
      S_SWAPWAIT: begin
        if (frame_start) begin
          front_d      = ~front_q;
          cur_page_d   = page_q;
          page_ready_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request arriving while busy replaces any older pending request
    if (req_ok_c && busy_now_c) begin
      pend_vld_d  = 1'b1;
      pend_page_d = page_num;
    end

    busy_d      = (state_d != S_IDLE) || pend_vld_d;
    disp_data_d = mem_q[{front_q, disp_addr}];
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      front_q      <= 1'b0;
      cur_page_q   <= '0;
      pend_vld_q   <= 1'b0;
      pend_page_q  <= '0;
      page_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      flash_addr_q <= '0;
      busy_q       <= 1'b0;
      page_ready_q <= 1'b0;
      req_error_q  <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      cur_page_q   <= cur_page_d;
      pend_vld_q   <= pend_vld_d;
      pend_page_q  <= pend_page_d;
      page_q       <= page_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      flash_addr_q <= flash_addr_d;
      busy_q       <= busy_d;
      page_ready_q <= page_ready_d;
      req_error_q  <= req_error_d;
      disp_data_q  <= disp_data_d;
    end
  end

  // Buffer write port; contents survive reset, writes suppressed while in reset
  always_ff @(posedge clock) begin
    if (nrst && wr_en_c) begin
      mem_q[wr_addr_c] <= flash_data;
    end
  end

  assign flash_address = flash_addr_q;
  assign disp_data     = disp_data_q;
  assign busy          = busy_q;
  assign page_ready    = page_ready_q;
  assign cur_page      = cur_page_q;
  assign req_error     = req_error_q;

endmodule
